alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand/result width; legal values are powers of two from 8 to 64.
REQ-002 Derived localparam SHW = $clog2(XLEN) SHALL set the shift-amount width.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 IN_VALID  input  1  SHALL indicate that OP/SRC_A/SRC_B carry a request.
REQ-006 IN_READY  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 OP  input  5  SHALL be the opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
REQ-008 SRC_A / SRC_B  input  XLEN  SHALL be operand A (rs1/pc) and operand B (rs2/immediate).
REQ-009 OUT_VALID  output  1  SHALL indicate that RESULT holds a completed result.
REQ-010 OUT_READY  input  1  SHALL indicate that the consumer takes RESULT this cycle.
REQ-011 RESULT  output  XLEN  SHALL be the registered result.
REQ-012 BUSY  output  1  SHALL be high while an iterative operation is in progress.

Function
REQ-013 A request SHALL be accepted in a cycle where IN_VALID && IN_READY.
REQ-014 IN_READY SHALL equal (state==IDLE) && (!OUT_VALID || OUT_READY).
REQ-015 FSM states SHALL be IDLE, MUL, DIV; OUT_VALID SHALL be a separate output-register flag.
REQ-016 Ops 0-10: RESULT and OUT_VALID SHALL be registered on the accept edge, giving latency 1 cycle.
REQ-017 Shifts SHALL use SRC_B[SHW-1:0] only; SRA SHALL sign-extend; SLT/SLTU SHALL return 1 or 0, zero-extended.
REQ-018 ADD/SUB SHALL wrap modulo 2^XLEN; PASSB SHALL return SRC_B.
REQ-019 Undefined opcodes (11-15, 24-31) SHALL return 0 with latency 1.
REQ-020 MUL family: IDLE->MUL on accept, then radix-2 shift-add over exactly XLEN cycles, MUL->IDLE with OUT_VALID set; latency XLEN+1.
REQ-021 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2XLEN-1:XLEN] with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-022 DIV family: IDLE->DIV on accept, restoring division over XLEN cycles on magnitudes, sign-corrected at the end; latency XLEN+1.
REQ-023 Divide by zero SHALL bypass iteration with latency 1: DIV/DIVU return all-ones, REM/REMU return SRC_A.
REQ-024 Signed overflow (SRC_A = -2^(XLEN-1), SRC_B = -1) SHALL bypass iteration with latency 1: DIV returns SRC_A, REM returns 0.
REQ-025 Signed remainder SHALL take the sign of the dividend; the quotient SHALL truncate toward zero.
REQ-026 Operands SHALL be captured at accept; later input changes SHALL NOT affect an in-flight op.
REQ-027 While OUT_VALID && !OUT_READY, RESULT SHALL be held stable and no new request SHALL be accepted.
REQ-028 When OUT_READY is high in the cycle an op completes, OUT_VALID SHALL stay high for the new result (back-to-back, no bubble).
REQ-029 BUSY SHALL be high exactly when state is MUL or DIV.

Reset
REQ-030 RST high at a clock edge SHALL force state=IDLE, OUT_VALID=0, RESULT=0, BUSY=0, and discard any in-flight op.
REQ-031 IN_READY SHALL be 1 in the first cycle after RST deasserts.

Configuration
REQ-032 Macro ALU_SEQ_MULDIV_EN defined: REQ-020 to REQ-025 are implemented.
REQ-033 ALU_SEQ_MULDIV_EN undefined: opcodes 16-23 SHALL behave as undefined opcodes (REQ-019), states MUL/DIV SHALL not exist, and BUSY SHALL be tied to 0.

Verification (XLEN=32)
REQ-034 ADD 0x7FFFFFFF+1 -> 0x80000000 one cycle after accept; SRA 0x80000000 by SRC_B=0x23 -> 0xF0000000 (shift 3).
REQ-035 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; each with OUT_VALID exactly 33 cycles after accept and BUSY high for 32 cycles.
REQ-036 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 latency 1.
REQ-037 Hold OUT_READY low for 5 cycles after a result -> RESULT stable, IN_READY low; then ADD and SUB issued back-to-back with OUT_READY=1 -> two consecutive OUT_VALID cycles.
REQ-038 Assert RST at cycle 10 of a DIVU -> next cycle OUT_VALID=0, BUSY=0, IN_READY=1, and no stale result appears afterwards.
REQ-039 Build without ALU_SEQ_MULDIV_EN -> MUL 3*4 returns 0 with latency 1 and BUSY never asserts.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: valid/ready request channel,
// valid/ready result channel and the busy flag.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, busy
  );

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle integer ops, plus iterative multiply/divide
// (opcodes 16-23) only when ALU_SEQ_MULDIV_EN is defined.
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  alu_seq_if.slave bus
);

  // state  | meaning
  // S_IDLE | waiting for a request (accepted once the output register is free)
  // S_MUL  | radix-2 shift-add, one multiplier bit per cycle
  // S_DIV  | restoring division on magnitudes, one quotient bit per cycle

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
`else
  typedef enum logic {S_IDLE} state_e;
`endif

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            in_ready;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign shamt    = bus.src_b[SHW-1:0];

`ifdef ALU_SEQ_MULDIV_EN
  logic            is_mul, is_div, div_zero, div_ovf, sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;

  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic            neg_q, neg_d;
  logic            negr_q, negr_d;
  logic [SHW-1:0]  cnt_q, cnt_d;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   div_rem_n, div_quo_n, quo, rem, div_res;

  always_comb begin
    is_mul   = (bus.op[4:2] == 3'b100);
    is_div   = (bus.op[4:2] == 3'b101);
    div_zero = (bus.src_b == '0);
    div_ovf  = (bus.src_a == INT_MIN) && (bus.src_b == '1) &&
               (bus.op == OP_DIV || bus.op == OP_REM);
    sgn_a    = bus.src_a[XLEN-1] && (bus.op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sgn_b    = bus.src_b[XLEN-1] && (bus.op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    mag_a    = sgn_a ? -bus.src_a : bus.src_a;
    mag_b    = sgn_b ? -bus.src_b : bus.src_b;
  end

  // {acc_q, lo_q} holds the partial product; lo_q starts as the multiplier.
  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  assign prod_mag = {mul_sum[XLEN:1], mul_sum[0], lo_q[XLEN-1:1]};
  assign prod     = neg_q ? -prod_mag : prod_mag;
  assign mul_res  = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // acc_q is the running remainder; lo_q shifts dividend bits out, quotient bits in.
  assign div_sh    = {acc_q, lo_q[XLEN-1]};
  assign div_diff  = div_sh - {1'b0, mcand_q};
  assign div_rem_n = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
  assign div_quo_n = {lo_q[XLEN-2:0], !div_diff[XLEN]};
  assign quo       = neg_q ? -div_quo_n : div_quo_n;
  assign rem       = negr_q ? -div_rem_n : div_rem_n;
  assign div_res   = (op_q == OP_DIV || op_q == OP_DIVU) ? quo : rem;
`endif

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:   alu_res = bus.src_a + bus.src_b;
      OP_SUB:   alu_res = bus.src_a - bus.src_b;
      OP_SLL:   alu_res = bus.src_a << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
      OP_XOR:   alu_res = bus.src_a ^ bus.src_b;
      OP_SRL:   alu_res = bus.src_a >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(bus.src_a) >>> shamt);
      OP_OR:    alu_res = bus.src_a | bus.src_b;
      OP_AND:   alu_res = bus.src_a & bus.src_b;
      OP_PASSB: alu_res = bus.src_b;
`ifdef ALU_SEQ_MULDIV_EN
      // Only consumed on the divide-by-zero / signed-overflow bypass.
      OP_DIV, OP_DIVU: alu_res = div_zero ? '1 : bus.src_a;
      OP_REM, 5'd23:   alu_res = div_zero ? bus.src_a : '0;
`endif
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
`ifdef ALU_SEQ_MULDIV_EN
    op_d    = op_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
          if (is_mul || (is_div && !div_zero && !div_ovf)) begin
            state_d = is_mul ? S_MUL : S_DIV;
            op_d    = bus.op;
            acc_d   = '0;
            lo_d    = is_mul ? mag_b : mag_a;
            mcand_d = is_mul ? mag_a : mag_b;
            neg_d   = sgn_a ^ sgn_b;
            negr_d  = sgn_a;
            cnt_d   = SHW'(XLEN-1);
          end else begin
            result_d    = alu_res;
            out_valid_d = 1'b1;
          end
`else
          result_d    = alu_res;
          out_valid_d = 1'b1;
`endif
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_MUL: begin
        acc_d = mul_sum[XLEN:1];
        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          result_d    = mul_res;
          out_valid_d = 1'b1;
        end
      end
      S_DIV: begin
        acc_d = div_rem_n;
        lo_d  = div_quo_n;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          result_d    = div_res;
          out_valid_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
`ifdef ALU_SEQ_MULDIV_EN
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
`ifdef ALU_SEQ_MULDIV_EN
  assign bus.busy = (state_q != S_IDLE);
`else
  assign bus.busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at XLEN=32; the mul/div scenarios
// follow whether ALU_SEQ_MULDIV_EN is defined for the build.
module tb_alu_seq;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  alu_seq_if #(.XLEN(XLEN)) bus ();

  alu_seq #(.XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for its result, consume it. Latency counts the
  // accept edge as 1; busy_cyc counts cycles with busy high before the result.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cyc);
    int w;
    w = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.src_a     = a;
    bus.src_b     = b;
    while (!bus.in_ready && w < 100) begin
      tick();
      w++;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.op       = 5'd0;
    bus.src_a    = ~a;
    bus.src_b    = ~b;
    lat      = 1;
    busy_cyc = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) busy_cyc++;
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    res = bus.result;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", bus.result);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_alu_ops;
    string       nm [16] = '{"add_wrap", "sub_wrap", "sll", "sll_mask", "slt", "sltu", "xor", "srl",
                             "sra_neg", "sra_pos", "or", "and", "passb", "undef12", "undef31", "undef15"};
    logic [4:0]  op [16] = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                             5'd7, 5'd7, 5'd8, 5'd9, 5'd10, 5'd12, 5'd31, 5'd15};
    logic [31:0] av [16] = '{32'h7FFFFFFF, 32'h0, 32'h1, 32'h80000001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hF0F0F0F0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h12340000,
                             32'hFF00FF00, 32'h1, 32'h5, 32'h5, 32'hFFFFFFFF};
    logic [31:0] bv [16] = '{32'h1, 32'h1, 32'h21, 32'h40, 32'h1, 32'h1, 32'hFF00FF00, 32'h4,
                             32'h23, 32'h1F, 32'h00005678, 32'h0F0F0F0F, 32'hDEADBEEF, 32'h3,
                             32'h3, 32'hFFFFFFFF};
    logic [31:0] ev [16] = '{32'h80000000, 32'hFFFFFFFF, 32'h2, 32'h80000001, 32'h1, 32'h0,
                             32'h0FF00FF0, 32'h08000000, 32'hF0000000, 32'h0, 32'h12345678,
                             32'h0F000F00, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    logic [31:0] res;
    int          lat, bc;
    for (int i = 0; i < 16; i++) begin
      run_op(op[i], av[i], bv[i], res, lat, bc);
      n_total++;
      if (res !== ev[i]) $display("FAIL %s result: got %h expected %h", nm[i], res, ev[i]);
      else n_pass++;
      n_total++;
      if (lat !== 1) $display("FAIL %s latency: got %0d expected 1", nm[i], lat);
      else n_pass++;
    end
  endtask

`ifdef ALU_SEQ_MULDIV_EN
  task automatic test_muldiv;
    string       nm [16] = '{"mul", "mulh", "mulhu", "mulhsu", "div_neg", "rem_neg", "div_negb",
                             "rem_negb", "divu", "remu", "divu_zero", "remu_zero", "div_zero",
                             "rem_zero", "div_ovf", "rem_ovf"};
    logic [4:0]  op [16] = '{5'd16, 5'd17, 5'd19, 5'd18, 5'd20, 5'd22, 5'd20, 5'd22, 5'd21,
                             5'd23, 5'd21, 5'd23, 5'd20, 5'd22, 5'd20, 5'd22};
    logic [31:0] av [16] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                             32'hFFFFFFF9, 32'd7, 32'd7, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    logic [31:0] bv [16] = '{32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                             32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0,
                             32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [16] = '{32'd12, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                             32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd14, 32'd2, 32'hFFFFFFFF,
                             32'd5, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h0};
    int          el [16] = '{33, 33, 33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 1, 1};
    logic [31:0] res;
    int          lat, bc;
    for (int i = 0; i < 16; i++) begin
      run_op(op[i], av[i], bv[i], res, lat, bc);
      n_total++;
      if (res !== ev[i]) $display("FAIL %s result: got %h expected %h", nm[i], res, ev[i]);
      else n_pass++;
      n_total++;
      if (lat !== el[i]) $display("FAIL %s latency: got %0d expected %0d", nm[i], lat, el[i]);
      else n_pass++;
      n_total++;
      if (bc !== el[i] - 1) $display("FAIL %s busy_cycles: got %0d expected %0d", nm[i], bc, el[i] - 1);
      else n_pass++;
    end
  endtask
`else
  task automatic test_no_muldiv;
    string       nm [4] = '{"mul_off", "mulhu_off", "divu_zero_off", "remu_off"};
    logic [4:0]  op [4] = '{5'd16, 5'd19, 5'd21, 5'd23};
    logic [31:0] av [4] = '{32'd3, 32'hFFFFFFFF, 32'd5, 32'd7};
    logic [31:0] bv [4] = '{32'd4, 32'hFFFFFFFF, 32'd0, 32'd3};
    logic [31:0] res;
    int          lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(op[i], av[i], bv[i], res, lat, bc);
      n_total++;
      if (res !== 32'h0) $display("FAIL %s result: got %h expected 00000000", nm[i], res);
      else n_pass++;
      n_total++;
      if (lat !== 1) $display("FAIL %s latency: got %0d expected 1", nm[i], lat);
      else n_pass++;
      n_total++;
      if (bc !== 0) $display("FAIL %s busy_cycles: got %0d expected 0", nm[i], bc);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_back_to_back;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 5'd0;
    bus.src_a     = 32'd1;
    bus.src_b     = 32'd2;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd3)
      $display("FAIL hold_first: got valid=%b result=%h expected valid=1 result=00000003", bus.out_valid, bus.result);
    else n_pass++;
    bus.src_a = 32'd100;
    bus.src_b = 32'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (bus.result !== 32'd3) $display("FAIL hold_result[%0d]: got %h expected 00000003", i, bus.result);
      else n_pass++;
      n_total++;
      if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
      else n_pass++;
      n_total++;
      if (bus.out_valid !== 1'b1) $display("FAIL hold_out_valid[%0d]: got %b expected 1", i, bus.out_valid);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    bus.src_a     = 32'd10;
    bus.src_b     = 32'd20;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd30)
      $display("FAIL b2b_add: got valid=%b result=%h expected valid=1 result=0000001e", bus.out_valid, bus.result);
    else n_pass++;
    bus.op    = 5'd1;
    bus.src_a = 32'd50;
    bus.src_b = 32'd8;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd42)
      $display("FAIL b2b_sub: got valid=%b result=%h expected valid=1 result=0000002a", bus.out_valid, bus.result);
    else n_pass++;
    bus.in_valid = 1'b0;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain: got valid=%b expected 0", bus.out_valid);
    else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_inflight;
    bit stale;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 5'd0;
    bus.src_a     = 32'd5;
    bus.src_b     = 32'd6;
    tick();
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd11)
      $display("FAIL pend_result: got valid=%b result=%h expected valid=1 result=0000000b", bus.out_valid, bus.result);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL pend_rst_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.result !== 32'h0) $display("FAIL pend_rst_result: got %h expected 00000000", bus.result);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL pend_rst_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;

`ifdef ALU_SEQ_MULDIV_EN
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 5'd21;
    bus.src_a     = 32'd1000;
    bus.src_b     = 32'd3;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL divu_busy_mid: got %b expected 1", bus.busy);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL divu_rst_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL divu_rst_busy: got %b expected 0", bus.busy);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL divu_rst_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) stale = 1'b1;
    end
    n_total++;
    if (stale !== 1'b0) $display("FAIL divu_stale_result: got out_valid seen=%b expected 0", stale);
    else n_pass++;
    bus.out_ready = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 5'd0;
    bus.src_a     = 32'h0;
    bus.src_b     = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_alu_ops();
`ifdef ALU_SEQ_MULDIV_EN
    test_muldiv();
`else
    test_no_muldiv();
`endif
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
